ex_mem_pipe_buf: RTL and testbench

Parametrised successor to the EX→MEM pipeline latch: carries WB/M control, destination register, ALU result and store data from EX to MEM, now with a valid/ready handshake, an optional registered skid entry, a flush that turns held beats into bubbles, and saturating stall/bubble counters. It sits between the EX stage and the data-memory stage. It replaces the hold-only latch wherever MEM can backpressure, for example on a cache miss.

---
 rtl/ex_mem_pkg.sv | 24 ++
 rtl/sat_counter.sv | 23 ++
 rtl/ex_mem_pipe_buf.sv | 143 ++++++++++++++
 tb/tb_ex_mem_pipe_buf.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX->MEM pipeline buffer.
// The payload struct matches the default widths; parametrised instances build their own.
package ex_mem_pkg;

    localparam int DEF_WB_W   = 2;
    localparam int DEF_M_W    = 2;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_WB_W-1:0]   wb;
        logic [DEF_M_W-1:0]    m;
        logic [DEF_REG_W-1:0]  reg_rd;
        logic [DEF_DATA_W-1:0] alu;
        logic [DEF_DATA_W-1:0] write_data;
    } ex_mem_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            count_reg <= '0;
        end else if (inc_i && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/ex_mem_pipe_buf.sv
// EX->MEM pipeline buffer with valid/ready handshake, optional skid entry,
// flush-to-bubble and saturating stall/bubble counters.
module ex_mem_pipe_buf
    import ex_mem_pkg::*;
#(
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              Clock_i,
    input  logic              Reset_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [M_W-1:0]    M_i,
    input  logic [REG_W-1:0]  RegRd_i,
    input  logic [DATA_W-1:0] ALU_i,
    input  logic [DATA_W-1:0] WriteData_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [M_W-1:0]    M_o,
    output logic [REG_W-1:0]  RegRd_o,
    output logic [DATA_W-1:0] ALU_o,
    output logic [DATA_W-1:0] WriteData_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [REG_W-1:0]  reg_rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] write_data;
    } payload_t;

    state_e   state_reg, state_next;
    payload_t main_reg, main_next;
    payload_t skid_reg, skid_next;
    payload_t in_pl;
    logic     valid_int, ready_int;
    logic     accept, deliver;

    assign in_pl     = {WB_i, M_i, RegRd_i, ALU_i, WriteData_i};
    assign valid_int = (state_reg != EMPTY);
    assign accept    = valid_i && ready_int;
    assign deliver   = valid_int && ready_i;

    // Without a skid entry, BUSY only accepts when MEM drains in the same
    // cycle, so the FULL transition is never taken.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = BUSY;
                    main_next  = in_pl;
                end
            end
            BUSY: begin
                if (accept && deliver) begin
                    main_next = in_pl;
                end else if (accept) begin
                    state_next = FULL;
                    skid_next  = in_pl;
                end else if (deliver) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    state_next = BUSY;
                    main_next  = skid_reg;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush turns everything into bubbles but leaves payload untouched.
        if (flush_i) begin
            state_next = EMPTY;
            main_next  = main_reg;
            skid_next  = skid_reg;
        end
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic ready_reg;
            always_ff @(posedge Clock_i) begin
                if (Reset_i) begin
                    ready_reg <= 1'b1;
                end else begin
                    ready_reg <= (state_next != FULL);
                end
            end
            assign ready_int = ready_reg;
        end else begin : g_noskid
            assign ready_int = ready_i || !valid_int;
        end
    endgenerate

    assign ready_o     = ready_int;
    assign valid_o     = valid_int;
    assign WB_o        = valid_int ? main_reg.wb : '0;
    assign M_o         = valid_int ? main_reg.m  : '0;
    assign RegRd_o     = main_reg.reg_rd;
    assign ALU_o       = main_reg.alu;
    assign WriteData_o = main_reg.write_data;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .Clock_i (Clock_i),
        .Reset_i (Reset_i),
        .inc_i   (valid_int && !ready_i),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .Clock_i (Clock_i),
        .Reset_i (Reset_i),
        .inc_i   (ready_i && !valid_int),
        .count_o (bubble_cnt_o)
    );

endmodule

// File: tb/tb_ex_mem_pipe_buf.sv
// Directed bench for ex_mem_pipe_buf: a SKID=1 and a SKID=0 instance share one
// stimulus stream; each scenario task checks the instance it targets.
module tb_ex_mem_pipe_buf;

    logic        clk = 1'b0;
    logic        rst, flush, vin, rin;
    logic [1:0]  wb_in, m_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_in, wd_in;

    logic        v1, r1, v0, r0;
    logic [1:0]  wb1, m1, wb0, m0;
    logic [4:0]  rd1, rd0;
    logic [31:0] alu1, wd1, alu0, wd0;
    logic [15:0] st1, bb1, st0, bb0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_buf #(.SKID(1'b1), .CNT_W(16)) dut1 (
        .Clock_i(clk), .Reset_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(r1),
        .WB_i(wb_in), .M_i(m_in), .RegRd_i(rd_in), .ALU_i(alu_in), .WriteData_i(wd_in),
        .valid_o(v1), .ready_i(rin), .WB_o(wb1), .M_o(m1), .RegRd_o(rd1), .ALU_o(alu1),
        .WriteData_o(wd1), .stall_cnt_o(st1), .bubble_cnt_o(bb1)
    );

    ex_mem_pipe_buf #(.SKID(1'b0), .CNT_W(16)) dut0 (
        .Clock_i(clk), .Reset_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(r0),
        .WB_i(wb_in), .M_i(m_in), .RegRd_i(rd_in), .ALU_i(alu_in), .WriteData_i(wd_in),
        .valid_o(v0), .ready_i(rin), .WB_o(wb0), .M_o(m0), .RegRd_o(rd0), .ALU_o(alu0),
        .WriteData_o(wd0), .stall_cnt_o(st0), .bubble_cnt_o(bb0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [1:0] wb, input logic [1:0] m,
                            input logic [4:0] rd, input logic [31:0] alu);
        vin    = v;
        wb_in  = wb;
        m_in   = m;
        rd_in  = rd;
        alu_in = alu;
        wd_in  = alu + 32'd1000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (v1 !== 1'b0)   begin fails++; $display("FAIL reset valid_o got %b exp 0", v1); end
        tests++; if (r1 !== 1'b1)   begin fails++; $display("FAIL reset ready_o got %b exp 1", r1); end
        tests++; if ({wb1, m1} !== 4'd0) begin fails++; $display("FAIL reset WB/M got %h exp 0", {wb1, m1}); end
        tests++; if ({rd1, alu1, wd1} !== 69'd0) begin fails++; $display("FAIL reset payload got %h exp 0", {rd1, alu1, wd1}); end
        tests++; if ({st1, bb1} !== 32'd0) begin fails++; $display("FAIL reset counters got %h exp 0", {st1, bb1}); end
        tests++; if (r0 !== 1'b1)   begin fails++; $display("FAIL reset noskid ready_o got %b exp 1", r0); end
    endtask

    task automatic test_back_to_back();
        rin = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_beat(1'b1, 2'(i), 2'(i + 1), 5'(i + 8), 32'(i));
            step();
            tests++;
            if (v1 !== 1'b1 || alu1 !== 32'(i) || wd1 !== 32'(i + 1000) || wb1 !== 2'(i) || rd1 !== 5'(i + 8)) begin
                fails++;
                $display("FAIL b2b beat%0d got v=%b alu=%0d wd=%0d wb=%0d rd=%0d exp v=1 alu=%0d", i, v1, alu1, wd1, wb1, rd1, i);
            end
            tests++;
            if (v0 !== 1'b1 || alu0 !== 32'(i)) begin
                fails++;
                $display("FAIL b2b noskid beat%0d got v=%b alu=%0d exp v=1 alu=%0d", i, v0, alu0, i);
            end
        end
        vin = 1'b0;
        step();
        rin = 1'b0;
        tests++; if (v1 !== 1'b0 || wb1 !== 2'd0) begin fails++; $display("FAIL b2b drain got v=%b wb=%0d exp v=0 wb=0", v1, wb1); end
        tests++; if (st1 !== 16'd0) begin fails++; $display("FAIL b2b stall_cnt got %0d exp 0", st1); end
        tests++; if (bb1 !== 16'd1) begin fails++; $display("FAIL b2b bubble_cnt got %0d exp 1", bb1); end
    endtask

    task automatic test_skid();
        rin = 1'b0;
        set_beat(1'b1, 2'd1, 2'd1, 5'd1, 32'd10);   // A
        step();
        tests++; if (v1 !== 1'b1 || alu1 !== 32'd10 || r1 !== 1'b1) begin fails++; $display("FAIL skid A got v=%b alu=%0d rdy=%b exp 1/10/1", v1, alu1, r1); end
        set_beat(1'b1, 2'd2, 2'd2, 5'd2, 32'd11);   // B, MEM stalled
        step();
        tests++; if (r1 !== 1'b0 || alu1 !== 32'd10) begin fails++; $display("FAIL skid full got rdy=%b alu=%0d exp 0/10", r1, alu1); end
        set_beat(1'b1, 2'd3, 2'd3, 5'd3, 32'd12);   // C, held upstream
        step();
        tests++; if (r1 !== 1'b0 || alu1 !== 32'd10) begin fails++; $display("FAIL skid hold got rdy=%b alu=%0d exp 0/10", r1, alu1); end
        step();
        tests++; if (st1 !== 16'd3 || alu1 !== 32'd10) begin fails++; $display("FAIL skid stall_cnt got %0d alu=%0d exp 3/10", st1, alu1); end
        rin = 1'b1;
        step();
        tests++; if (alu1 !== 32'd11 || r1 !== 1'b1) begin fails++; $display("FAIL skid order B got alu=%0d rdy=%b exp 11/1", alu1, r1); end
        step();
        tests++; if (alu1 !== 32'd12 || v1 !== 1'b1) begin fails++; $display("FAIL skid order C got alu=%0d v=%b exp 12/1", alu1, v1); end
        vin = 1'b0;
        step();
        rin = 1'b0;
        tests++; if (v1 !== 1'b0 || st1 !== 16'd3) begin fails++; $display("FAIL skid drain got v=%b stall=%0d exp 0/3", v1, st1); end
    endtask

    task automatic test_flush();
        rin = 1'b0;
        set_beat(1'b1, 2'd1, 2'd1, 5'd4, 32'd20);   // X
        step();
        set_beat(1'b1, 2'd2, 2'd2, 5'd5, 32'd21);   // Y into skid
        step();
        tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL flush prefill ready got %b exp 0", r1); end
        set_beat(1'b1, 2'b11, 2'b11, 5'd6, 32'd22); // Z, dropped
        flush = 1'b1;
        step();
        flush = 1'b0;
        vin   = 1'b0;
        rin   = 1'b1;
        tests++; if (v1 !== 1'b0 || wb1 !== 2'd0 || m1 !== 2'd0 || r1 !== 1'b1) begin fails++; $display("FAIL flush outputs got v=%b wb=%0d m=%0d rdy=%b exp 0/0/0/1", v1, wb1, m1, r1); end
        tests++; if (alu1 !== 32'd20) begin fails++; $display("FAIL flush payload hold got alu=%0d exp 20", alu1); end
        tests++; if (st1 !== 16'd5) begin fails++; $display("FAIL flush stall_cnt got %0d exp 5", st1); end
        step();
        step();
        tests++; if (v1 !== 1'b0 || bb1 !== 16'd3) begin fails++; $display("FAIL flush no-reappear got v=%b bubble=%0d exp 0/3", v1, bb1); end
    endtask

    task automatic test_reset_flush();
        rin = 1'b1;
        set_beat(1'b1, 2'd3, 2'd3, 5'd7, 32'd30);
        step();
        tests++; if (v1 !== 1'b1 || st1 !== 16'd5) begin fails++; $display("FAIL rstflush pre got v=%b stall=%0d exp 1/5", v1, st1); end
        rst   = 1'b1;
        flush = 1'b1;
        set_beat(1'b1, 2'd2, 2'd2, 5'd8, 32'd31);
        step();
        rst   = 1'b0;
        flush = 1'b0;
        vin   = 1'b0;
        rin   = 1'b0;
        tests++; if (v1 !== 1'b0 || r1 !== 1'b1 || {wb1, m1} !== 4'd0) begin fails++; $display("FAIL rstflush ctl got v=%b rdy=%b wbm=%h exp 0/1/0", v1, r1, {wb1, m1}); end
        tests++; if ({rd1, alu1, wd1} !== 69'd0) begin fails++; $display("FAIL rstflush payload got %h exp 0", {rd1, alu1, wd1}); end
        tests++; if (st1 !== 16'd0 || bb1 !== 16'd0) begin fails++; $display("FAIL rstflush counters got %0d/%0d exp 0/0", st1, bb1); end
        tests++; if (alu0 !== 32'd0 || v0 !== 1'b0) begin fails++; $display("FAIL rstflush noskid got alu=%0d v=%b exp 0/0", alu0, v0); end
    endtask

    task automatic test_noskid();
        rin = 1'b0;
        set_beat(1'b1, 2'd1, 2'd2, 5'd9, 32'd40);
        step();
        tests++; if (v0 !== 1'b1 || alu0 !== 32'd40) begin fails++; $display("FAIL noskid load got v=%b alu=%0d exp 1/40", v0, alu0); end
        tests++; if (r0 !== 1'b0) begin fails++; $display("FAIL noskid ready comb-low got %b exp 0", r0); end
        rin = 1'b1;
        set_beat(1'b1, 2'd2, 2'd1, 5'd10, 32'd41);
        #1;
        tests++; if (r0 !== 1'b1) begin fails++; $display("FAIL noskid ready comb-high got %b exp 1", r0); end
        step();
        tests++; if (v0 !== 1'b1 || alu0 !== 32'd41 || wb0 !== 2'd2) begin fails++; $display("FAIL noskid pass got v=%b alu=%0d wb=%0d exp 1/41/2", v0, alu0, wb0); end
        vin = 1'b0;
        step();
        rin = 1'b0;
        tests++; if (v0 !== 1'b0) begin fails++; $display("FAIL noskid drain got v=%b exp 0", v0); end
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vin = 1'b0;
        rin = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        tests++; if (bb1 !== 16'd65534) begin fails++; $display("FAIL sat pre got %0d exp 65534", bb1); end
        repeat (6) @(posedge clk);
        #1;
        tests++; if (bb1 !== 16'hFFFF) begin fails++; $display("FAIL sat bubble_cnt got %0d exp 65535", bb1); end
        tests++; if (bb0 !== 16'hFFFF || st1 !== 16'd0) begin fails++; $display("FAIL sat noskid/stall got %0d/%0d exp 65535/0", bb0, st1); end
        rin = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        rin   = 1'b0;
        set_beat(1'b0, 2'd0, 2'd0, 5'd0, 32'd0);
        test_reset();
        test_back_to_back();
        test_skid();
        test_flush();
        test_reset_flush();
        test_noskid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
